// File: rtl/rdma_msix_fire_pkg.sv
// Shared MSI-X definitions: vector count, table-entry layout and FSM encoding.
package rdma_msix_fire_pkg;

  localparam int MSIX_NUM_LOG = 4;
  localparam int MSIX_NUM     = 1 << MSIX_NUM_LOG;
  localparam int MSIX_DATA_W  = 128;

  localparam int ENT_ADDR_LSB = 0;
  localparam int ENT_DATA_LSB = 64;
  localparam int ENT_MASK_BIT = 96;

  // One-hot FSM encoding
  localparam logic [3:0] ST_IDLE   = 4'b0001;
  localparam logic [3:0] ST_LOOKUP = 4'b0010;
  localparam logic [3:0] ST_WAIT   = 4'b0100;
  localparam logic [3:0] ST_ISSUE  = 4'b1000;

  typedef struct packed {
    logic        mask;
    logic [31:0] data;
    logic [63:0] addr;
  } msix_entry_t;

  function automatic msix_entry_t decode_entry(input logic [ENT_MASK_BIT:0] raw);
    msix_entry_t e;
    e.addr = raw[ENT_ADDR_LSB +: 64];
    e.data = raw[ENT_DATA_LSB +: 32];
    e.mask = raw[ENT_MASK_BIT];
    return e;
  endfunction

endpackage

// File: rtl/pcieifc_pri_enc.sv
// Lowest-index-set-bit priority encoder.
module pcieifc_pri_enc #(
  parameter int WIDTH = 16,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  always_comb begin
    o_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = i[IDX_W-1:0];
    end
  end

  assign o_valid = |i_vec;

endmodule

// File: rtl/rdma_msix_fire.sv
// MSI-X fire engine: looks up the vector's table entry, issues the posted write,
// or records the vector as pending and retries it periodically while masked.
module rdma_msix_fire
  import rdma_msix_fire_pkg::*;
#(
  parameter logic [15:0] RETRY_INTERVAL = 16'd1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    eq_int_valid,
  input  logic [MSIX_NUM_LOG-1:0] eq_int_num,
  output logic                    eq_int_ready,
  output logic                    tbl_req_valid,
  output logic [MSIX_NUM_LOG-1:0] tbl_req_num,
  input  logic                    tbl_req_ready,
  input  logic                    tbl_rsp_valid,
  input  logic [MSIX_DATA_W-1:0]  tbl_rsp_data,
  output logic                    tbl_rsp_ready,
  output logic                    msix_wr_valid,
  output logic [63:0]             msix_wr_addr,
  output logic [31:0]             msix_wr_data,
  input  logic                    msix_wr_ready,
  output logic [MSIX_NUM-1:0]     pba
);

  localparam logic [15:0] TIMER_MAX = RETRY_INTERVAL - 16'd1;

  logic [3:0]              r_state;
  logic [MSIX_NUM_LOG-1:0] r_vec;
  logic [MSIX_NUM-1:0]     r_pba;
  logic [15:0]             r_timer;
  logic [63:0]             r_addr;
  logic [31:0]             r_data;

  msix_entry_t             w_entry;
  logic [MSIX_NUM_LOG-1:0] w_retry_idx;
  logic                    w_pba_any;
  logic                    w_expired;
  logic                    w_retry;
  logic                    w_unused_rsp;

  assign w_entry      = decode_entry(tbl_rsp_data[ENT_MASK_BIT:0]);
  assign w_unused_rsp = ^tbl_rsp_data[MSIX_DATA_W-1:ENT_MASK_BIT+1];

  pcieifc_pri_enc #(.WIDTH(MSIX_NUM)) u_pri_enc (
    .i_vec   (r_pba),
    .o_idx   (w_retry_idx),
    .o_valid (w_pba_any)
  );

  assign w_expired = (r_timer == TIMER_MAX);
  // A fresh request always wins over a retry in the same idle cycle
  assign w_retry   = (r_state == ST_IDLE) && !eq_int_valid && w_expired && w_pba_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (!w_pba_any || w_retry) begin
      r_timer <= '0;
    end else if (!w_expired) begin
      r_timer <= r_timer + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_vec   <= '0;
      r_pba   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (eq_int_valid) begin
            r_vec   <= eq_int_num;
            r_state <= ST_LOOKUP;
          end else if (w_retry) begin
            r_vec   <= w_retry_idx;
            r_state <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (tbl_req_ready) r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (tbl_rsp_valid) begin
            if (w_entry.mask) begin
              r_pba[r_vec] <= 1'b1;
              r_state      <= ST_IDLE;
            end else begin
              // Message writes are DW-aligned; low address bits are dropped
              r_addr  <= {w_entry.addr[63:2], 2'b00};
              r_data  <= w_entry.data;
              r_state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (msix_wr_ready) begin
            r_pba[r_vec] <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Ready is held low while reset is asserted, so nothing is accepted before release
  assign eq_int_ready  = (r_state == ST_IDLE) && rst_n;
  assign tbl_req_valid = (r_state == ST_LOOKUP);
  assign tbl_req_num   = r_vec;
  assign tbl_rsp_ready = (r_state == ST_WAIT);
  assign msix_wr_valid = (r_state == ST_ISSUE);
  assign msix_wr_addr  = r_addr;
  assign msix_wr_data  = r_data;
  assign pba           = r_pba;

endmodule

// File: tb/tb_rdma_msix_fire.sv
// Directed bench for rdma_msix_fire: table-driven fires plus masked/retry,
// priority and reset-in-flight sequences.
module tb_rdma_msix_fire;

  localparam logic [15:0] RI = 16'd32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         eq_int_valid = 1'b0;
  logic [3:0]   eq_int_num = '0;
  logic         eq_int_ready;
  logic         tbl_req_valid;
  logic [3:0]   tbl_req_num;
  logic         tbl_req_ready = 1'b1;
  logic         tbl_rsp_valid = 1'b0;
  logic [127:0] tbl_rsp_data = '0;
  logic         tbl_rsp_ready;
  logic         msix_wr_valid;
  logic [63:0]  msix_wr_addr;
  logic [31:0]  msix_wr_data;
  logic         msix_wr_ready = 1'b0;
  logic [15:0]  pba;

  int n_cmp = 0;
  int n_fail = 0;
  int n_wr = 0;

  always #5 clk = ~clk;

  rdma_msix_fire #(.RETRY_INTERVAL(RI)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .eq_int_valid  (eq_int_valid),
    .eq_int_num    (eq_int_num),
    .eq_int_ready  (eq_int_ready),
    .tbl_req_valid (tbl_req_valid),
    .tbl_req_num   (tbl_req_num),
    .tbl_req_ready (tbl_req_ready),
    .tbl_rsp_valid (tbl_rsp_valid),
    .tbl_rsp_data  (tbl_rsp_data),
    .tbl_rsp_ready (tbl_rsp_ready),
    .msix_wr_valid (msix_wr_valid),
    .msix_wr_addr  (msix_wr_addr),
    .msix_wr_data  (msix_wr_data),
    .msix_wr_ready (msix_wr_ready),
    .pba           (pba)
  );

  always @(posedge clk) begin
    if (msix_wr_valid && msix_wr_ready) n_wr++;
  end

  typedef struct {
    string        nm;
    logic [3:0]   num;
    logic [127:0] rsp;
    logic [63:0]  exp_addr;
    logic [31:0]  exp_data;
    int           stall;
  } vec_t;

  function automatic logic [127:0] ent(input logic [30:0] junk, input logic m,
                                        input logic [31:0] d, input logic [63:0] a);
    return {junk, m, d, a};
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Answers one table lookup and completes the resulting write (if unmasked).
  task automatic serve(input string nm, input logic [3:0] exp_num, input logic [127:0] rsp,
                       input logic [63:0] exp_addr, input logic [31:0] exp_data,
                       input int stall, input bit hold_req, input logic [3:0] hold_num,
                       output int k);
    int  w0;
    bit  stable;
    w0 = n_wr;
    k  = 0;
    while (!tbl_req_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!tbl_req_valid) begin
      chk({nm, "_lookup_timeout"}, 0, 1);
      return;
    end
    if (eq_int_valid) eq_int_valid = 1'b0;
    chk({nm, "_req_num"}, tbl_req_num, exp_num);
    @(negedge clk);
    chk({nm, "_rsp_ready"}, tbl_rsp_ready, 1);
    tbl_rsp_valid = 1'b1;
    tbl_rsp_data  = rsp;
    @(negedge clk);
    tbl_rsp_valid = 1'b0;
    if (!rsp[96]) begin
      chk({nm, "_wr_valid"}, msix_wr_valid, 1);
      chk({nm, "_wr_addr"}, msix_wr_addr, exp_addr);
      chk({nm, "_wr_data"}, msix_wr_data, exp_data);
      stable = 1'b1;
      for (int i = 0; i < stall; i++) begin
        if (i == 0 && hold_req) begin
          eq_int_valid = 1'b1;
          eq_int_num   = hold_num;
        end
        @(negedge clk);
        if (msix_wr_valid !== 1'b1 || msix_wr_addr !== exp_addr ||
            msix_wr_data !== exp_data || eq_int_ready !== 1'b0) stable = 1'b0;
      end
      chk({nm, "_stall_stable"}, stable, 1);
      msix_wr_ready = 1'b1;
      @(negedge clk);
      msix_wr_ready = 1'b0;
    end
    chk({nm, "_wr_valid_low"}, msix_wr_valid, 0);
    chk({nm, "_idle_ready"}, eq_int_ready, 1);
    chk({nm, "_wr_count"}, n_wr - w0, rsp[96] ? 0 : 1);
  endtask

  task automatic do_txn(input string nm, input logic [3:0] num, input logic [127:0] rsp,
                        input logic [63:0] exp_addr, input logic [31:0] exp_data,
                        input int stall, input bit hold_req, input logic [3:0] hold_num);
    int k;
    chk({nm, "_accept_ready"}, eq_int_ready, 1);
    eq_int_valid = 1'b1;
    eq_int_num   = num;
    serve(nm, num, rsp, exp_addr, exp_data, stall, hold_req, hold_num, k);
    chk({nm, "_latency"}, k, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tv[4];
    int   k;
    int   w0;

    tv[0] = '{"fire5", 4'd5, ent(31'h0, 1'b0, 32'h0000_0025, 64'h0000_0001_FEE0_0004),
              64'h0000_0001_FEE0_0004, 32'h0000_0025, 0};
    tv[1] = '{"bp1", 4'd1, ent(31'h0, 1'b0, 32'hDEAD_BEEF, 64'h0000_0000_FEE0_1000),
              64'h0000_0000_FEE0_1000, 32'hDEAD_BEEF, 20};
    tv[2] = '{"mis15", 4'd15, ent(31'h0, 1'b0, 32'h0000_0001, 64'hFFFF_FFFF_FFFF_0003),
              64'hFFFF_FFFF_FFFF_0000, 32'h0000_0001, 2};
    tv[3] = '{"junk0", 4'd0, ent(31'h7FFF_FFFF, 1'b0, 32'hA5A5_5A5A, 64'h1234_5678_9ABC_DEF1),
              64'h1234_5678_9ABC_DEF0, 32'hA5A5_5A5A, 1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tbl_req_valid", tbl_req_valid, 0);
    chk("rst_tbl_rsp_ready", tbl_rsp_ready, 0);
    chk("rst_wr_valid", msix_wr_valid, 0);
    chk("rst_pba", pba, 0);
    chk("rst_eq_ready_low", eq_int_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_eq_ready", eq_int_ready, 1);

    for (int i = 0; i < 4; i++) begin
      do_txn(tv[i].nm, tv[i].num, tv[i].rsp, tv[i].exp_addr, tv[i].exp_data,
             tv[i].stall, 1'b0, 4'd0);
      chk({tv[i].nm, "_pba"}, pba, 0);
    end

    // Masked vector becomes pending, then is retried after RI cycles
    do_txn("mask3", 4'd3, ent(31'h0, 1'b1, 32'h33, 64'h100), 64'h0, 32'h0, 0, 1'b0, 4'd0);
    chk("mask3_pba", pba, 16'h0008);
    serve("retry3", 4'd3, ent(31'h0, 1'b0, 32'h0000_0033, 64'h0000_0000_FEE0_0030),
          64'h0000_0000_FEE0_0030, 32'h0000_0033, 0, 1'b0, 4'd0, k);
    chk("retry3_interval", k, RI);
    chk("retry3_pba", pba, 0);

    // A new request for a pending vector fires normally and clears its bit
    do_txn("mask12", 4'd12, ent(31'h0, 1'b1, 32'h0, 64'h0), 64'h0, 32'h0, 0, 1'b0, 4'd0);
    chk("mask12_pba", pba, 16'h1000);
    do_txn("fire12", 4'd12, ent(31'h0, 1'b0, 32'h12, 64'h0000_0000_FEE0_0120),
           64'h0000_0000_FEE0_0120, 32'h12, 0, 1'b0, 4'd0);
    chk("fire12_pba", pba, 0);

    // New request and expired retry collide: request 9 first, then 2, then 7
    do_txn("mask2", 4'd2, ent(31'h0, 1'b1, 32'h0, 64'h0), 64'h0, 32'h0, 0, 1'b0, 4'd0);
    do_txn("mask7", 4'd7, ent(31'h0, 1'b1, 32'h0, 64'h0), 64'h0, 32'h0, 0, 1'b0, 4'd0);
    chk("pri_pba", pba, 16'h0084);
    do_txn("busy4", 4'd4, ent(31'h0, 1'b0, 32'h44, 64'h0000_0000_FEE0_0040),
           64'h0000_0000_FEE0_0040, 32'h44, 40, 1'b1, 4'd9);
    serve("pri9", 4'd9, ent(31'h0, 1'b0, 32'h99, 64'h0000_0000_FEE0_0090),
          64'h0000_0000_FEE0_0090, 32'h99, 0, 1'b0, 4'd0, k);
    chk("pri9_latency", k, 1);
    serve("pri2", 4'd2, ent(31'h0, 1'b0, 32'h22, 64'h0000_0000_FEE0_0020),
          64'h0000_0000_FEE0_0020, 32'h22, 0, 1'b0, 4'd0, k);
    chk("pri2_latency", k, 1);
    chk("pri2_pba", pba, 16'h0080);
    serve("pri7", 4'd7, ent(31'h0, 1'b0, 32'h77, 64'h0000_0000_FEE0_0070),
          64'h0000_0000_FEE0_0070, 32'h77, 0, 1'b0, 4'd0, k);
    chk("pri7_pba", pba, 0);

    // Reset asserted while a write is waiting
    do_txn("mask10", 4'd10, ent(31'h0, 1'b1, 32'h0, 64'h0), 64'h0, 32'h0, 0, 1'b0, 4'd0);
    chk("mask10_pba", pba, 16'h0400);
    eq_int_valid = 1'b1;
    eq_int_num   = 4'd6;
    @(negedge clk);
    eq_int_valid = 1'b0;
    @(negedge clk);
    tbl_rsp_valid = 1'b1;
    tbl_rsp_data  = ent(31'h0, 1'b0, 32'h66, 64'h0000_0000_FEE0_0060);
    @(negedge clk);
    tbl_rsp_valid = 1'b0;
    chk("rstiss_wr_valid", msix_wr_valid, 1);
    w0 = n_wr;
    #2 rst_n = 1'b0;
    #1;
    chk("rstiss_async_wr_valid", msix_wr_valid, 0);
    chk("rstiss_pba", pba, 0);
    chk("rstiss_eq_ready", eq_int_ready, 0);
    msix_wr_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tbl_rsp_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk("rstiss_no_write", n_wr - w0, 0);
    chk("rstiss_wr_valid_low", msix_wr_valid, 0);
    chk("rstiss_rsp_not_taken", tbl_rsp_ready, 0);
    chk("rstiss_eq_ready_rel", eq_int_ready, 1);
    tbl_rsp_valid = 1'b0;
    msix_wr_ready = 1'b0;
    do_txn("post_rst", 4'd6, ent(31'h0, 1'b0, 32'h66, 64'h0000_0000_FEE0_0062),
           64'h0000_0000_FEE0_0060, 32'h66, 0, 1'b0, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rdma_msix_fire.md
RDMA_MSIX_FIRE -- requirements
Module: rdma_msix_fire

Interface
REQ-001 Parameter RETRY_INTERVAL, default 16'd1024, cycles between retries of a masked (pending) vector.
REQ-002 clk  in  1  the single clock.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 eq_int_valid / eq_int_num / eq_int_ready  in / in / out  1 / `RDMA_MSIX_NUM_LOG / 1  interrupt request from the EQ engine.
REQ-005 tbl_req_valid / tbl_req_num / tbl_req_ready  out / out / in  1 / `RDMA_MSIX_NUM_LOG / 1  MSI-X table lookup request to rdma_int.
REQ-006 tbl_rsp_valid / tbl_rsp_data / tbl_rsp_ready  in / in / out  1 / `RDMA_MSIX_DATA_W (128) / 1  table entry returned by rdma_int.
REQ-007 msix_wr_valid / msix_wr_addr / msix_wr_data / msix_wr_ready  out / out / out / in  1 / 64 / 32 / 1  posted MSI-X memory-write request to the DMA write path.
REQ-008 pba  out  2**`RDMA_MSIX_NUM_LOG  pending bit array, one bit per vector.

Function
REQ-009 Entry decode: [63:0] message address, [95:64] message data, [96] mask bit; [127:97] are ignored.
REQ-010 FSM states: IDLE, LOOKUP, WAIT_RSP, ISSUE; one-hot encoded.
REQ-011 IDLE: eq_int_ready=1; on eq_int_valid, latch eq_int_num into vec_reg, go to LOOKUP.
REQ-012 IDLE with no eq_int_valid, retry timer expired, pba nonzero: vec_reg = lowest-index set pba bit, clear timer, go to LOOKUP; eq_int_ready stays 1 in that cycle, and a new request takes priority over a retry.
REQ-013 LOOKUP: tbl_req_valid=1, tbl_req_num=vec_reg; go to WAIT_RSP when tbl_req_ready=1.
REQ-014 WAIT_RSP: tbl_rsp_ready=1; on tbl_rsp_valid with mask=1, set pba[vec_reg] and go to IDLE; with mask=0, latch addr and data and go to ISSUE.
REQ-015 ISSUE: msix_wr_valid=1; addr/data stay stable until msix_wr_ready; on handshake, clear pba[vec_reg] and go to IDLE.
REQ-016 msix_wr_addr[1:0] is forced to 2'b00 (DW alignment); upper bits pass through unchanged.
REQ-017 Minimum latency: eq_int accept in cycle N; tbl_req_valid in N+1; msix_wr_valid in the cycle after the tbl_rsp handshake.
REQ-018 One transaction is in flight at a time; eq_int_ready=0 in every state except IDLE.
REQ-019 Retry timer (16 bit): counts up each cycle while pba!=0 and saturates at RETRY_INTERVAL-1, which means expired; it clears when pba==0 or when a retry is launched.
REQ-020 A new request for a vector already pending is processed normally; if it fires, that pba bit clears.
REQ-021 pba set and clear for the same index never coincide, because only vec_reg is updated per transaction.
REQ-022 Valid outputs never depend combinationally on the matching ready input.

Reset
REQ-023 On rst_n low: state=IDLE, pba=0, timer=0, vec_reg=0, latched addr/data=0; tbl_req_valid, tbl_rsp_ready and msix_wr_valid are 0, and eq_int_ready becomes 1 after release.
REQ-024 Reset during any state aborts the transaction with no write issued; an outstanding table response after reset is not accepted until a new LOOKUP.

Structure
REQ-025 `RDMA_MSIX_NUM_LOG, `RDMA_MSIX_DATA_W and the entry bit-field offsets (addr, data, mask) are defined in the shared PCIe interface define file.
REQ-026 The lowest-set-bit priority encoder for pba is one sub-module, pcieifc_pri_enc, parameterised by width.
REQ-027 The FSM, timer and output registers are inline; there are no other sub-modules.

Verification
REQ-028 Unmasked fire: eq_int num=5, entry {mask=0, data=32'h0000_0025, addr=64'h0000_0001_FEE0_0004} -> one msix_wr addr=64'h0000_0001_FEE0_0004, data=32'h25; pba unchanged.
REQ-029 Masked: num=3, mask=1 -> no msix_wr; pba[3]=1. After RETRY_INTERVAL cycles, tbl_req num=3 reissued; next response mask=0 -> write issued and pba[3]=0.
REQ-030 Back-pressure: msix_wr_ready held 0 for 20 cycles -> addr/data stable, eq_int_ready=0 throughout; exactly one write completes.
REQ-031 Priority: pba[2]=pba[7]=1 with timer expired and eq_int_valid num=9 in the same cycle -> vector 9 looked up first, then vector 2, then vector 7.
REQ-032 Misaligned address 64'h...0003 -> msix_wr_addr ends in 2'b00.
REQ-033 rst_n asserted in ISSUE -> msix_wr_valid low asynchronously, pba=0, no write on release.
